// File: rtl/hdlink_pkg.sv
// Shared definitions for the half-duplex link transmitter: frame geometry,
// line levels and the transmitter state encoding.
package hdlink_pkg;

  localparam int   DATA_BITS  = 8;
  localparam int   FRAME_BITS = 10;
  localparam logic START_LVL  = 1'b0;
  localparam logic STOP_LVL   = 1'b1;
  localparam logic IDLE_LVL   = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_TURN  = 3'd4
  } state_e;

  // True in the states where this node owns the shared line.
  function automatic logic drives_line(input state_e s);
    return (s == ST_START) || (s == ST_DATA) || (s == ST_STOP);
  endfunction

endpackage

// File: rtl/hdlink_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while run is high, flags the
// last cycle of each bit and the mid-bit cycle used for line readback.
module hdlink_bit_timer
  import hdlink_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic bit_end,
  output logic sample
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: wraps at the bit boundary, held at zero while the line is not driven.
  always_comb begin
    cnt_d = cnt_q;
    if (!run) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_end = run && (cnt_q == CW'(CLKS_PER_BIT - 1));
  assign sample  = run && (cnt_q == CW'(CLKS_PER_BIT / 2));

endmodule

// File: rtl/hdlink_tx.sv
// Half-duplex serial transmitter. Sends start/8 data (LSB first)/stop bits
// onto a shared line through an external tristate buffer, reads the line back
// mid-bit to detect collisions, and releases the line for a turnaround period
// after every frame or abort.
module hdlink_tx
  import hdlink_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int TURN_CYCLES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       bus_in,
  output logic       drv_data,
  output logic       drv_en,
  output logic       tx_done,
  output logic       collision
);

  localparam int BW = $clog2(DATA_BITS);
  localparam int TW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;

  state_e               state_q, state_d;
  logic [BW-1:0]        bit_idx_q, bit_idx_d;
  logic [TW-1:0]        turn_cnt_q, turn_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 drv_en_q, drv_en_d;
  logic                 drv_data_q, drv_data_d;
  logic                 tx_done_q, tx_done_d;
  logic                 collision_q, collision_d;

  logic accept;
  logic bit_end;
  logic sample;
  logic mismatch;

  hdlink_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk     (clk),
    .rst     (rst),
    .run     (drives_line(state_q)),
    .bit_end (bit_end),
    .sample  (sample)
  );

  assign tx_ready = (state_q == ST_IDLE) && !rst;
  assign accept   = tx_valid && tx_ready;
  // Readback is compared against the level we are currently driving.
  assign mismatch = sample && (bus_in != drv_data_q);

  // Frame sequencing: next state, next line levels and status pulses.
  always_comb begin
    state_d     = state_q;
    bit_idx_d   = bit_idx_q;
    turn_cnt_d  = turn_cnt_q;
    shift_d     = shift_q;
    drv_en_d    = drv_en_q;
    drv_data_d  = drv_data_q;
    tx_done_d   = 1'b0;
    collision_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d    = ST_START;
          shift_d    = tx_data;
          bit_idx_d  = '0;
          drv_en_d   = 1'b1;
          drv_data_d = START_LVL;
        end
      end

      ST_START, ST_DATA, ST_STOP: begin
        if (mismatch) begin
          // Someone else is on the line: back off immediately.
          state_d     = ST_TURN;
          turn_cnt_d  = '0;
          drv_en_d    = 1'b0;
          drv_data_d  = IDLE_LVL;
          collision_d = 1'b1;
        end else if (bit_end) begin
          if (state_q == ST_START) begin
            state_d    = ST_DATA;
            bit_idx_d  = '0;
            drv_data_d = shift_q[0];
            shift_d    = shift_q >> 1;
          end else if (state_q == ST_DATA) begin
            if (bit_idx_q == BW'(DATA_BITS - 1)) begin
              state_d    = ST_STOP;
              drv_data_d = STOP_LVL;
            end else begin
              bit_idx_d  = bit_idx_q + 1'b1;
              drv_data_d = shift_q[0];
              shift_d    = shift_q >> 1;
            end
          end else begin
            state_d    = ST_TURN;
            turn_cnt_d = '0;
            drv_en_d   = 1'b0;
            drv_data_d = IDLE_LVL;
            tx_done_d  = 1'b1;
          end
        end
      end

      ST_TURN: begin
        if (turn_cnt_q == TW'(TURN_CYCLES - 1)) begin
          state_d    = ST_IDLE;
          turn_cnt_d = '0;
        end else begin
          turn_cnt_d = turn_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d    = ST_IDLE;
        drv_en_d   = 1'b0;
        drv_data_d = IDLE_LVL;
      end
    endcase
  end

  // Control and output registers; reset releases the line and drops any frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bit_idx_q   <= '0;
      turn_cnt_q  <= '0;
      drv_en_q    <= 1'b0;
      drv_data_q  <= IDLE_LVL;
      tx_done_q   <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_idx_q   <= bit_idx_d;
      turn_cnt_q  <= turn_cnt_d;
      drv_en_q    <= drv_en_d;
      drv_data_q  <= drv_data_d;
      tx_done_q   <= tx_done_d;
      collision_q <= collision_d;
    end
  end

  // Payload shift register; its contents only matter while a frame is active.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  assign drv_en    = drv_en_q;
  assign drv_data  = drv_data_q;
  assign tx_done   = tx_done_q;
  assign collision = collision_q;

endmodule

// File: doc/hdlink_tx.md
HDLINK_TX -- requirements
Module: hdlink_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 4, clock cycles per serial bit (even, >=4).
REQ-002 SHALL have parameter TURN_CYCLES, default 2, bus-release cycles after every frame or abort (>=1).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 tx_data  input  8  byte to transmit, sampled on accept.
REQ-006 tx_valid  input  1  tx_data is valid.
REQ-007 tx_ready  output  1  block can accept a byte this cycle.
REQ-008 bus_in  input  1  readback of the shared line (downstream of the tristate buffer).
REQ-009 drv_data  output  1  data to the tristate buffer's data_in.
REQ-010 drv_en  output  1  enable to the tristate buffer; 0 releases the line (Z).
REQ-011 tx_done  output  1  one-cycle pulse, frame completed without collision.
REQ-012 collision  output  1  one-cycle pulse, readback mismatch detected; frame aborted.

Function
REQ-013 Frame: start bit 0, 8 data bits LSB first, stop bit 1; 10 bits of CLKS_PER_BIT cycles each.
REQ-014 States: IDLE, START, DATA, STOP, TURN.
REQ-015 tx_ready = 1 only in IDLE with rst low; accept = tx_valid && tx_ready.
REQ-016 Accept at edge N: tx_data latched; state->START; drv_en=1, drv_data=0 from cycle N+1.
REQ-017 tx_valid without tx_ready is ignored; tx_data changes after accept have no effect on the frame.
REQ-018 START->DATA after CLKS_PER_BIT cycles; DATA->STOP after 8 bits; STOP->TURN after CLKS_PER_BIT cycles.
REQ-019 drv_en=1 in START, DATA, STOP; drv_en=0 in IDLE and TURN.
REQ-020 drv_data=1 whenever drv_en=0.
REQ-021 drv_en and drv_data SHALL be registered outputs (no combinational path from inputs).
REQ-022 Bit-cycle counter runs 0..CLKS_PER_BIT-1; bus_in sampled when counter == CLKS_PER_BIT/2 in START, DATA, STOP.
REQ-023 Sampled bus_in != drv_data: collision pulses the next cycle, drv_en=0 the next cycle, state->TURN, no tx_done.
REQ-024 tx_done pulses in the first TURN cycle after a normal STOP.
REQ-025 tx_done and collision SHALL never assert in the same cycle.
REQ-026 TURN lasts exactly TURN_CYCLES cycles, then IDLE; tx_ready returns in the first IDLE cycle.
REQ-027 tx_valid held high continuously: back-to-back frames are separated by exactly TURN_CYCLES+1 cycles of drv_en=0 (TURN plus the IDLE accept cycle).
REQ-028 Bus_in is not sampled in IDLE or TURN; collision cannot assert there.

Reset
REQ-029 While rst=1: state IDLE, counters 0, drv_en=0, drv_data=1, tx_ready=0, tx_done=0, collision=0.
REQ-030 Reset mid-frame: line released on the edge after rst is sampled high; no tx_done or collision is produced for the aborted frame.
REQ-031 First cycle with rst=0: tx_ready=1.

Structure
REQ-032 State encodings, frame length (10), data width (8) and start/stop levels SHALL live in shared package hdlink_pkg.
REQ-033 Bit timing SHALL be a sub-module hdlink_bit_timer (counter, bit-end strobe, sample strobe), parameterised by CLKS_PER_BIT.
REQ-034 Top-level drv_data/drv_en SHALL connect to the existing tristate buffer; this block contains no tristate logic itself.

Verification
REQ-035 Reset: hold rst 3 cycles -> drv_en=0, drv_data=1, tx_ready=0; release -> tx_ready=1 next cycle.
REQ-036 Send 0xA5 with bus_in looped from drv_data (CLKS_PER_BIT=4):
- drv_en high for 40 cycles.
- Line sequence 0,1,0,1,0,0,1,0,1,1.
- tx_done pulse, 2 TURN cycles, then tx_ready=1.
REQ-037 Collision: send 0xFF, force bus_in=0 during data bit 2 -> collision pulses once, drv_en=0 next cycle, no tx_done, tx_ready after 2 TURN cycles.
REQ-038 Back-to-back: tx_valid held with 0x3C then 0xC3 -> two tx_done pulses; drv_en=0 for exactly 3 cycles between frames.
REQ-039 Reset mid-frame: assert rst during data bit 3 of 0x55 -> drv_en=0 next edge, no tx_done or collision; new 0x0F after release transmits correctly.
REQ-040 Ignore when busy: pulse tx_valid with 0x99 during a frame -> not sent; only the original byte appears on the line.
